param_data_cache: RTL and testbench
===================================

PARAM_DATA_CACHE -- requirements
Module: param_data_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width (multiple of 8).
REQ-003 SHALL have parameter SETS, default 128, number of sets (power of two).
REQ-004 SHALL have parameter WAYS, default 2, associativity (power of two, 2..8).
REQ-005 SHALL have parameter WORDS, default 4, words per line (power of two, 1..16).
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports cpu_req_valid / cpu_req_ready, input / output, 1 each: request handshake.
REQ-009 SHALL have ports cpu_we (input, 1), cpu_addr (input, ADDR_W), cpu_wdata (input, DATA_W) and cpu_be (input, DATA_W/8).
REQ-010 SHALL have ports cpu_resp_valid (output, 1), a one-cycle completion pulse, and cpu_rdata (output, DATA_W).
REQ-011 SHALL have ports mem_req, mem_we (output, 1 each), mem_addr (output, ADDR_W, word-aligned beat address) and mem_wdata (output, DATA_W).
REQ-012 SHALL have ports mem_rdata (input, DATA_W) and mem_ack (input, 1, per-beat completion).
REQ-013 SHALL have port c_state, output, 3, encoding of the current state.

Function
REQ-014 Address split SHALL be: byte offset log2(DATA_W/8) bits (ignored), word offset log2(WORDS) bits, index log2(SETS) bits, tag the remaining bits.
REQ-015 States SHALL be IDLE, LOOKUP, WRITEBACK, FILL and RESPOND; cpu_req_ready SHALL be high only in IDLE.
REQ-016 On handshake in IDLE, the block SHALL register the request, issue a data read of all ways at that index/word, and go to LOOKUP.
REQ-017 In LOOKUP, a hit is valid && tag match; at most one way SHALL match.
REQ-018 On a read hit, LOOKUP SHALL go to RESPOND, with cpu_rdata the hit word and cpu_resp_valid high for exactly that cycle (2 cycles after accept).
REQ-019 On a write hit, LOOKUP SHALL write cpu_wdata under cpu_be into the hit word, set dirty (also when cpu_be==0), and go to RESPOND; cpu_rdata is don't-care.
REQ-020 On a miss, the victim SHALL be the lowest-index invalid way, else the way with the maximum LRU age; a dirty victim SHALL go to WRITEBACK, else to FILL.
REQ-021 WRITEBACK SHALL hold mem_req=1, mem_we=1 and the victim tag/index/beat address for each of the WORDS beats, advancing the beat on mem_ack; after the last beat it SHALL go to FILL.
REQ-022 FILL SHALL hold mem_req=1, mem_we=0 for WORDS beats and write mem_rdata into the victim on each mem_ack; after the last beat it SHALL set tag, valid=1 and dirty=0, then replay LOOKUP, which then hits.
REQ-023 mem_req SHALL drop in the cycle after the final mem_ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-024 LRU: on each hit, the accessed way age SHALL become 0 and ways with a smaller old age SHALL increment; ages SHALL remain a permutation of 0..WAYS-1.
REQ-025 cpu inputs outside the handshake SHALL be ignored; back-to-back requests SHALL be accepted in the cycle after RESPOND.

Reset
REQ-026 While reset_n=0, the block SHALL be in state IDLE, every valid and dirty bit SHALL be 0, the age of way i SHALL be i, the beat counter SHALL be 0, and all outputs SHALL be 0 except cpu_req_ready=1.
REQ-027 Reset mid-burst SHALL abandon the transaction and drop mem_req immediately; data RAM contents SHALL NOT be cleared.

Configuration
REQ-028 With DCACHE_STATS_EN defined, the block SHALL add outputs hit_count and miss_count (32-bit, saturating, reset to 0); each SHALL increment once per LOOKUP, excluding replays.
REQ-029 Without DCACHE_STATS_EN, these ports and their logic SHALL be absent.

Structure
REQ-030 Package dcache_pkg SHALL hold the state enum, the address-field struct and the width-derivation functions.
REQ-031 Submodule dcache_data_ram SHALL be a per-way synchronous single-port RAM of SETS*WORDS x DATA_W with byte enables and 1-cycle read latency; tags, valid, dirty and ages SHALL be flops in the top module.

Verification
REQ-032 Read 0x100 after reset, mem_rdata = beat index + 0xA0 -> 4 fill beats at 0x100..0x10C, then cpu_rdata=0xA0.
REQ-033 Write 0x104 = 0xDEADBEEF with be=4'b0011, then read 0x104 -> 0x0000BEEF | (old & 0xFFFF0000), no mem_req, latency 2.
REQ-034 WAYS=2: fill tags A and B at one set, touch A, miss C -> B evicted; if B was dirty, 4 writeback beats precede the fill.
REQ-035 Hold mem_ack low for 10 cycles mid-fill -> mem_req held with a stable beat address, no cpu_resp_valid.
REQ-036 Assert reset_n=0 during WRITEBACK beat 2 -> mem_req=0 immediately; the next read of that address misses.
REQ-037 With DCACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the parameterised data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_RESPOND   = 3'd4
    } dcache_state_e;

    // Fields are sized for the widest supported geometry; callers truncate.
    typedef struct packed {
        logic [63:0] tag;
        logic [31:0] index;
        logic [31:0] word;
    } dcache_addr_t;

    function automatic int off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int safe_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic dcache_addr_t split_addr(input logic [63:0] addr, input int off_w,
                                                input int word_w, input int idx_w);
        dcache_addr_t f;
        logic [63:0]  a;
        a       = addr >> off_w;
        f.word  = a[31:0] & ((32'd1 << word_w) - 32'd1);
        a       = a >> word_w;
        f.index = a[31:0] & ((32'd1 << idx_w) - 32'd1);
        f.tag   = a >> idx_w;
        return f;
    endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// One way of cache data: synchronous single-port RAM, byte enables, 1-cycle read.
module dcache_data_ram #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-first: a write returns the previous contents of the word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/param_data_cache.sv
// Set-associative write-back data cache with LRU replacement and burst line refill.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
//
// state     | meaning
// IDLE      | ready for a request; data read of all ways issued on accept
// LOOKUP    | tag compare; hit -> RESPOND, miss -> WRITEBACK or FILL
// WRITEBACK | dirty victim line streamed to memory, one beat per mem_ack
// FILL      | line fetched into the victim way, then LOOKUP is replayed
// RESPOND   | one-cycle completion pulse
module param_data_cache
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 128,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
`ifdef DCACHE_STATS_EN
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
`endif
    output logic [2:0]          c_state
);

    localparam int OFF_W = off_bits(DATA_W);
    localparam int WO_W  = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - WO_W - IDX_W;
    localparam int BT_W  = safe_bits(WORDS);
    localparam int IX_W  = safe_bits(SETS);
    localparam int WAY_W = safe_bits(WAYS);
    localparam int RA_W  = safe_bits(SETS * WORDS);
    localparam int BE_W  = DATA_W / 8;

    dcache_state_e state_q, next_state;

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];

    logic [TAG_W-1:0]  req_tag;
    logic [IX_W-1:0]   req_idx;
    logic [BT_W-1:0]   req_word;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;

    logic [BT_W-1:0]   beat_q, beat_next;
    logic [WAY_W-1:0]  victim_q;
    logic              replay_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] fill_word_q;

    dcache_addr_t      addr_f;
    logic              hit, found, last_beat;
    logic [WAY_W-1:0]  hit_way, victim;
    logic [DATA_W-1:0] lookup_word;

    logic [WAYS-1:0]              ram_we;
    logic [BE_W-1:0]              ram_be;
    logic [DATA_W-1:0]            ram_wdata;
    logic [IX_W-1:0]              ram_idx;
    logic [BT_W-1:0]              ram_word;
    logic [RA_W-1:0]              ram_addr;
    logic [WAYS-1:0][DATA_W-1:0]  ram_rdata;

    always_comb begin
        addr_f    = split_addr(64'(cpu_addr), OFF_W, WO_W, IDX_W);
        last_beat = (beat_q == BT_W'(WORDS - 1));
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // The replayed lookup cannot read the RAM (it was busy writing the last beat),
        // so the requested word is taken from the copy captured during the fill.
        lookup_word = replay_q ? fill_word_q : ram_rdata[hit_way];
    end

    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[req_idx][w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age_q[req_idx][w] > age_q[req_idx][victim]) victim = WAY_W'(w);
            end
        end
    end

    always_comb begin
        beat_next = beat_q;
        if ((state_q == ST_WRITEBACK || state_q == ST_FILL) && mem_ack)
            beat_next = last_beat ? '0 : beat_q + 1'b1;
    end

    always_comb begin
        next_state = state_q;
        ram_we     = '0;
        ram_be     = req_be;
        ram_wdata  = req_wdata;
        ram_idx    = req_idx;
        ram_word   = beat_q;
        case (state_q)
            ST_IDLE: begin
                ram_idx  = IX_W'(addr_f.index);
                ram_word = BT_W'(addr_f.word);
                if (cpu_req_valid) next_state = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    ram_word        = req_word;
                    ram_we[hit_way] = req_we;
                    next_state      = ST_RESPOND;
                end else begin
                    // Prefetch beat 0 so write-back data is ready on the first cycle.
                    ram_word   = '0;
                    next_state = (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ?
                                 ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                ram_word = beat_next;
                if (mem_ack && last_beat) next_state = ST_FILL;
            end
            ST_FILL: begin
                ram_wdata        = mem_rdata;
                ram_be           = '1;
                ram_we[victim_q] = mem_ack;
                if (mem_ack && last_beat) next_state = ST_LOOKUP;
            end
            ST_RESPOND: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
        ram_addr = RA_W'((32'(ram_idx) << WO_W) | 32'(ram_word));
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_data_ram #(
            .DEPTH  (SETS * WORDS),
            .DATA_W (DATA_W),
            .ADDR_W (RA_W)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we[w]),
            .be    (ram_be),
            .addr  (ram_addr),
            .wdata (ram_wdata),
            .rdata (ram_rdata[w])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            victim_q    <= '0;
            replay_q    <= 1'b0;
            rdata_q     <= '0;
            fill_word_q <= '0;
            req_tag     <= '0;
            req_idx     <= '0;
            req_word    <= '0;
            req_we      <= 1'b0;
            req_wdata   <= '0;
            req_be      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            state_q <= next_state;
            beat_q  <= beat_next;
            if (state_q == ST_IDLE && cpu_req_valid) begin
                req_tag   <= TAG_W'(addr_f.tag);
                req_idx   <= IX_W'(addr_f.index);
                req_word  <= BT_W'(addr_f.word);
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
                req_be    <= cpu_be;
            end
            if (state_q == ST_LOOKUP) begin
                replay_q <= 1'b0;
                if (hit) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == hit_way)
                            age_q[req_idx][w] <= '0;
                        else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                    end
                    if (req_we) dirty_q[req_idx][hit_way] <= 1'b1;
                    else        rdata_q <= lookup_word;
                end else begin
                    victim_q <= victim;
                end
            end
            if (state_q == ST_FILL && mem_ack) begin
                if (beat_q == req_word) fill_word_q <= mem_rdata;
                if (last_beat) begin
                    valid_q[req_idx][victim_q] <= 1'b1;
                    dirty_q[req_idx][victim_q] <= 1'b0;
                    replay_q                   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_FILL && mem_ack && last_beat) tag_q[req_idx][victim_q] <= req_tag;
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == ST_LOOKUP && !replay_q) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        cpu_req_ready  = (state_q == ST_IDLE);
        cpu_resp_valid = (state_q == ST_RESPOND);
        cpu_rdata      = rdata_q;
        mem_req        = (state_q == ST_WRITEBACK) || (state_q == ST_FILL);
        mem_we         = (state_q == ST_WRITEBACK);
        mem_addr       = '0;
        mem_wdata      = '0;
        if (mem_req) begin
            mem_addr = (ADDR_W'(mem_we ? tag_q[req_idx][victim_q] : req_tag) << (IDX_W + WO_W + OFF_W))
                     | (ADDR_W'(req_idx) << (WO_W + OFF_W))
                     | (ADDR_W'(beat_q) << OFF_W);
        end
        if (mem_we) mem_wdata = ram_rdata[victim_q];
    end

    assign c_state = state_q;

endmodule

// File: tb/tb_param_data_cache.sv
// Directed self-checking bench for param_data_cache at its default geometry.
module tb_param_data_cache;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req_valid, cpu_req_ready, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_be;
    logic        cpu_resp_valid;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  c_state;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    param_data_cache u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_be         (cpu_be),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_rdata      (cpu_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
`ifdef DCACHE_STATS_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`endif
        .c_state        (c_state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] fill_base = 32'h0;
    logic        stall     = 1'b0;
    int          wb_beats   = 0;
    int          fill_beats = 0;
    logic [63:0] wb_q [$];
    logic [31:0] fill_q [$];

    logic [31:0] rd;
    int          lat, n, held, stable, resp_seen;
    logic [31:0] exp_wb [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: one-cycle ack per beat, read data = fill_base + word-in-line.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !stall) begin
                mem_ack   = 1'b1;
                mem_rdata = fill_base + 32'(mem_addr[3:2]);
                if (mem_we) begin
                    wb_beats++;
                    wb_q.push_back({mem_addr, mem_wdata});
                end else begin
                    fill_beats++;
                    fill_q.push_back(mem_addr);
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h5A5A_5A5A;
            end
        end
    end

    task automatic clear_log();
        wb_beats   = 0;
        fill_beats = 0;
        wb_q.delete();
        fill_q.delete();
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_we        = we;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        cpu_be        = be;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        cpu_we        = ~we;
        cpu_addr      = 32'hFFFF_FFF0;
        cpu_wdata     = 32'hFFFF_FFFF;
        cpu_be        = 4'hF;
    endtask

    task automatic wait_resp(output logic [31:0] rdata, output int latency);
        latency = 0;
        rdata   = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (cpu_resp_valid) begin
                latency = i;
                rdata   = cpu_rdata;
                break;
            end
        end
        if (latency == 0) check("resp_timeout", 0, 1);
    endtask

    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output int latency);
        clear_log();
        issue(we, addr, wdata, be);
        wait_resp(rdata, latency);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_we        = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        cpu_be        = '0;
        exp_wb        = '{32'h0000_00A0, 32'h0000_BEEF, 32'h1234_00A2, 32'h0000_00A3};

        repeat (3) @(negedge clk);
        check("rst_state", c_state, 0);
        check("rst_ready", cpu_req_ready, 1);
        check("rst_resp_valid", cpu_resp_valid, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;

        // cold read miss: four refill beats, then word 0 of the line
        fill_base = 32'hA0;
        cpu_access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        check("miss_rdata", rd, 32'hA0);
        check("miss_fill_beats", fill_beats, 4);
        check("miss_wb_beats", wb_beats, 0);
        for (int i = 0; i < fill_q.size(); i++) check("miss_fill_addr", fill_q[i], 32'h100 + 32'(4 * i));

        // partial-byte write hits and read-back
        cpu_access(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, rd, lat);
        check("wr_hit_lat", lat, 2);
        check("wr_hit_mem_beats", fill_beats + wb_beats, 0);
        cpu_access(1'b0, 32'h104, 32'h0, 4'h0, rd, lat);
        check("rd_after_wr_lo", rd, 32'h0000_BEEF);
        check("rd_hit_lat", lat, 2);
        check("rd_hit_mem_beats", fill_beats + wb_beats, 0);
        cpu_access(1'b1, 32'h108, 32'h1234_5678, 4'b1100, rd, lat);
        cpu_access(1'b0, 32'h108, 32'h0, 4'h0, rd, lat);
        check("rd_after_wr_hi", rd, 32'h1234_00A2);

        // replacement in set 16: A=0x100 (dirty), B=0x900, C=0x1100, D=0x1900
        fill_base = 32'hB0;
        cpu_access(1'b0, 32'h900, 32'h0, 4'h0, rd, lat);
        check("fill_b_rdata", rd, 32'hB0);
        check("fill_b_wb_beats", wb_beats, 0);
        cpu_access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        check("touch_a_lat", lat, 2);
        fill_base = 32'hC0;
        cpu_access(1'b0, 32'h1100, 32'h0, 4'h0, rd, lat);
        check("fill_c_rdata", rd, 32'hC0);
        check("fill_c_wb_beats", wb_beats, 0);
        check("fill_c_fill_beats", fill_beats, 4);
        cpu_access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        check("a_kept_lat", lat, 2);
        check("a_kept_rdata", rd, 32'hA0);
        cpu_access(1'b1, 32'h1100, 32'h0, 4'b0000, rd, lat);
        check("wr_be0_lat", lat, 2);
        fill_base = 32'hD0;
        cpu_access(1'b0, 32'h1900, 32'h0, 4'h0, rd, lat);
        check("evict_a_wb_beats", wb_beats, 4);
        check("evict_a_fill_beats", fill_beats, 4);
        check("evict_a_rdata", rd, 32'hD0);
        for (int i = 0; i < wb_q.size() && i < 4; i++)
            check("evict_a_wb_beat", wb_q[i], {32'h100 + 32'(4 * i), exp_wb[i]});

        // reset during write-back of C (dirty from a be=0 write)
        fill_base = 32'hE0;
        clear_log();
        issue(1'b0, 32'h2100, 32'h0, 4'h0);
        n = 0;
        while (wb_beats < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wb_beat2_state", c_state, 2);
        reset_n = 1'b0;
        #1;
        check("rst_mid_wb_mem_req", mem_req, 0);
        check("rst_mid_wb_state", c_state, 0);
        check("rst_mid_wb_ready", cpu_req_ready, 1);
        if (wb_q.size() >= 2) begin
            check("evict_c_wb_beat0", wb_q[0], {32'h1100, 32'hC0});
            check("evict_c_wb_beat1", wb_q[1], {32'h1104, 32'hC1});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fill_base = 32'hC0;
        cpu_access(1'b0, 32'h1100, 32'h0, 4'h0, rd, lat);
        check("post_rst_fill_beats", fill_beats, 4);
        check("post_rst_wb_beats", wb_beats, 0);
        check("post_rst_rdata", rd, 32'hC0);

        // memory stall mid-fill
        fill_base = 32'h50;
        clear_log();
        issue(1'b0, 32'h300, 32'h0, 4'h0);
        n = 0;
        while (fill_beats < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        stall     = 1'b1;
        held      = 0;
        stable    = 0;
        resp_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b0) held++;
            if (mem_addr === 32'h308) stable++;
            if (cpu_resp_valid !== 1'b0) resp_seen++;
        end
        check("stall_req_held", held, 10);
        check("stall_addr_stable", stable, 10);
        check("stall_no_resp", resp_seen, 0);
        stall = 1'b0;
        wait_resp(rd, lat);
        check("stall_rdata", rd, 32'h50);
        check("stall_fill_beats", fill_beats, 4);

        // three hits after two misses since reset
        cpu_access(1'b0, 32'h1100, 32'h0, 4'h0, rd, lat);
        check("hit1_rdata", rd, 32'hC0);
        check("hit1_lat", lat, 2);
        cpu_access(1'b0, 32'h300, 32'h0, 4'h0, rd, lat);
        check("hit2_rdata", rd, 32'h50);
        cpu_access(1'b0, 32'h1104, 32'h0, 4'h0, rd, lat);
        check("hit3_rdata", rd, 32'hC1);
        check("hit3_mem_beats", fill_beats + wb_beats, 0);
`ifdef DCACHE_STATS_EN
        check("stats_hit_count", hit_count, 3);
        check("stats_miss_count", miss_count, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
